// File: rtl/lif_post_neuron.sv
`default_nettype none
// ============================================================================
// Module   : lif_post_neuron
// Purpose  : Single leaky integrate-and-fire post-synaptic neuron with a
//            saturating membrane, an optional refractory period and a
//            saturating spike counter for debug readout.
// Ports    : clk          - clock, all state updates on rising edge
//            rst          - synchronous active-high reset
//            en           - step enable; low freezes all state
//            pre_spike    - pre-synaptic spikes, bit i = synapse i
//            weight       - packed weights, synapse 0 in the top nibble
//            post_spike   - registered one-cycle fire pulse
//            membrane     - current membrane potential
//            refractory   - high while in the refractory state
//            spike_count  - saturating count of fires since reset
// Revision : 1.0 - initial release
// ============================================================================
module lif_post_neuron #(
  parameter int NUM_PRE        = 4,
  parameter int W_WIDTH        = 4,
  parameter int V_WIDTH        = 8,
  parameter int THRESHOLD      = 40,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic                       post_spike,
  output logic [V_WIDTH-1:0]         membrane,
  output logic                       refractory,
  output logic [7:0]                 spike_count
);

  // Synaptic sum width: enough for NUM_PRE full-scale weights.
  localparam int SYN_W = W_WIDTH + $clog2(NUM_PRE);
  // Refractory counter width; kept at least 1 bit when the period is 0.
  localparam int RC_W  = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0]    RC_LOAD = RC_W'(REFRACT_CYCLES);
  localparam logic [V_WIDTH-1:0] THRESH  = V_WIDTH'(THRESHOLD);

  typedef enum logic [0:0] {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } state_t;

  state_t            state;
  logic [RC_W-1:0]   refract_cnt;

  logic [SYN_W-1:0]   syn;
  logic [V_WIDTH-1:0] v_leak;
  logic [V_WIDTH:0]   v_sum;
  logic [V_WIDTH-1:0] v_sat;
  logic               fire;

  // Sum the weights of every synapse that spiked this step.
  always_comb begin
    syn = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (pre_spike[i]) begin
        syn = syn + SYN_W'(weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
      end
    end
  end

  // The leak term never exceeds v, so the subtraction cannot wrap; only the
  // add of the synaptic input needs the extra carry bit for saturation.
  always_comb begin
    v_leak = membrane - (membrane >> LEAK_SHIFT);
    v_sum  = {1'b0, v_leak} + (V_WIDTH+1)'(syn);
    v_sat  = v_sum[V_WIDTH] ? {V_WIDTH{1'b1}} : v_sum[V_WIDTH-1:0];
    fire   = (v_sat >= THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INTEGRATE;
      refract_cnt <= '0;
      membrane    <= '0;
      post_spike  <= 1'b0;
      spike_count <= '0;
    end else if (!en) begin
      post_spike  <= 1'b0;
    end else begin
      case (state)
        ST_INTEGRATE: begin
          if (fire) begin
            post_spike <= 1'b1;
            membrane   <= '0;
            if (spike_count != 8'hFF) begin
              spike_count <= spike_count + 8'd1;
            end
            if (REFRACT_CYCLES > 0) begin
              state       <= ST_REFRACTORY;
              refract_cnt <= RC_LOAD;
            end
          end else begin
            post_spike <= 1'b0;
            membrane   <= v_sat;
          end
        end
        ST_REFRACTORY: begin
          // Inputs are ignored; leaving on the edge where the count is 1
          // spends exactly REFRACT_CYCLES enabled edges here.
          post_spike  <= 1'b0;
          membrane    <= '0;
          refract_cnt <= refract_cnt - RC_W'(1);
          if (refract_cnt == RC_W'(1)) begin
            state <= ST_INTEGRATE;
          end
        end
        default: begin
          state <= ST_INTEGRATE;
        end
      endcase
    end
  end

  assign refractory = (state == ST_REFRACTORY);

endmodule
`default_nettype wire

// File: doc/lif_post_neuron.md
Name: lif_post_neuron

Overview:
- Single leaky integrate-and-fire post-synaptic neuron.
- Sits directly upstream of the STDP timing/weight stage. It consumes the same 4-bit pre-synaptic spike vector and the packed 16-bit weight vector that the STDP stage produces.
- It generates the post_spike pulse that the STDP stage times against.
- Adds a refractory period, a saturating membrane and a spike counter for debug readout.

Parameters:
- NUM_PRE, 4: number of pre-synaptic inputs. Fixed at 4 for the packed weight layout.
- W_WIDTH, 4: bits per synaptic weight (unsigned).
- V_WIDTH, 8: membrane potential width (unsigned, saturating).
- THRESHOLD, 40: firing threshold. The neuron fires when the next membrane value is >= THRESHOLD. Legal range 1..2^V_WIDTH-1.
- LEAK_SHIFT, 3: leak per step = v >> LEAK_SHIFT.
- REFRACT_CYCLES, 4: enabled cycles ignored after a spike. A value of 0 means no refractory period.

Ports:
- clk, input, 1: the single clock. All state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: step enable. When low, all state is frozen.
- pre_spike, input, 4: pre-synaptic spikes, sampled each enabled cycle. Bit i is synapse i.
- weight, input, 16: packed weights. weight[15:12] = synapse 0, [11:8] = synapse 1, [7:4] = synapse 2, [3:0] = synapse 3.
- post_spike, output, 1: registered one-cycle fire pulse.
- membrane, output, 8: current membrane potential (registered state).
- refractory, output, 1: high while in the REFRACTORY state.
- spike_count, output, 8: saturating count of fires since reset.

Behaviour:

Reset (rst=1 at a clock edge):
- Membrane = 0, state = INTEGRATE, refract_cnt = 0.
- post_spike = 0, refractory = 0, spike_count = 0.
- rst overrides en and all other inputs, and aborts any state, including mid-refractory.

States: INTEGRATE, REFRACTORY. The refractory output equals (state == REFRACTORY).

en = 0:
- Membrane, state, refract_cnt and spike_count hold.
- post_spike is driven 0 at that edge.

INTEGRATE, each edge with en = 1:
- syn = sum of weight_i over the set bits pre_spike[i]. Width 6 bits, maximum 60.
- v_next = v - (v >> LEAK_SHIFT) + syn, computed at V_WIDTH+1 bits.
- v_next is clamped to 2^V_WIDTH-1 (255) on overflow. Underflow is impossible because the leak is <= v.
- If v_next >= THRESHOLD:
  - post_spike <= 1 and membrane <= 0.
  - spike_count <= spike_count + 1, saturating at 255.
  - If REFRACT_CYCLES > 0: state <= REFRACTORY and refract_cnt <= REFRACT_CYCLES. Otherwise stay in INTEGRATE.
- Else: membrane <= v_next and post_spike <= 0.

REFRACTORY, each edge with en = 1:
- pre_spike and weight are ignored. Membrane stays 0 and post_spike <= 0.
- refract_cnt decrements. When refract_cnt == 1 at the edge, state <= INTEGRATE.
- Net effect: exactly REFRACT_CYCLES enabled edges are spent in REFRACTORY.

Latency and pulse rules:
- Inputs sampled at edge k produce post_spike high in the cycle after edge k, with membrane = 0 in that same cycle.
- post_spike is never high for two consecutive cycles when REFRACT_CYCLES > 0.
- With REFRACT_CYCLES = 0, back-to-back spikes are legal.
- Weight changes take effect on the next enabled integrate edge. No shadowing.

Test Plan:
1. Burst fire: rst, then all weights 0xF, pre_spike = 4'b1111 held.
   - Edge 1: syn = 60 >= 40, so post_spike = 1, membrane = 0, refractory = 1, spike_count = 1.
   - Next 4 enabled edges: post_spike = 0, membrane = 0.
   - Edge 6: fires again, spike_count = 2.
2. Accumulate with leak: weight = 16'hA000, pre_spike = 4'b0001 held.
   - Membrane goes 10, 19, 27, 34.
   - Edge 5: v_next = 40, so post_spike = 1 and membrane = 0.
3. Leak floor: weight = 16'h8000, a single-cycle pre_spike = 4'b0001, then 0.
   - Membrane goes 8, then 7, then holds at 7 (7 >> 3 = 0). post_spike stays 0.
4. Enable freeze: during scenario 2, drop en for 3 cycles after membrane = 19.
   - Membrane holds 19, post_spike = 0.
   - On resume the sequence continues at 27.
5. Reset mid-refractory: in scenario 1, assert rst during the 2nd refractory cycle.
   - Next cycle: refractory = 0, membrane = 0, spike_count = 0, post_spike = 0.
   - With inputs still held, the neuron fires on the first edge after rst is released.
6. Counter saturation: REFRACT_CYCLES = 0, scenario 1 stimulus held for 300 cycles.
   - post_spike is high every cycle.
   - spike_count reaches 255 and holds at 255.
